ps2_host: RTL
=============

Name: ps2_host

Overview:
- Bidirectional PS/2 host controller: receives device-to-host frames with full framing and parity checking, and transmits host-to-device command bytes (e.g. 0xFF reset, 0xED LEDs) using the standard request-to-send sequence.
- Sits between the open-drain SB_IO pads (pull-ups enabled) and the keyboard/mouse logic.
- Adds glitch filtering, frame timeouts, error reporting and a byte-level valid/ready transmit interface.

Parameters:
- FILTER_LEN, 8, samples of synchronised ps2_clk that must agree before the filtered clock changes.
- INHIBIT_CYCLES, 1600, clk cycles ps2_clk is held low before a transmit (≥100 µs at 16 MHz).
- TIMEOUT_CYCLES, 32000, maximum clk cycles between consecutive device clock falling edges inside a frame (2 ms).
- TIMER_WIDTH, 16, width of the shared inhibit/timeout counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk_in  in  1  pad input of the PS/2 clock line
- ps2_data_in  in  1  pad input of the PS/2 data line
- ps2_clk_oe  out  1  1 = drive the PS/2 clock line low; 0 = release
- ps2_data_oe  out  1  1 = drive the PS/2 data line low; 0 = release
- rx_data  out  8  last correctly received byte
- rx_valid  out  1  one-cycle pulse: rx_data updated
- rx_error  out  1  one-cycle pulse: frame rejected (bad start, parity or stop bit, or timeout)
- tx_data  in  8  byte to send
- tx_valid  in  1  transmit request
- tx_ready  out  1  transmit request accepted this cycle when tx_valid=1
- tx_done  out  1  one-cycle pulse: transmit finished
- tx_error  out  1  qualifies tx_done: 1 = no ACK from the device, or timeout
- busy  out  1  state is not IDLE

Behaviour:
- Reset values: all outputs 0, except rx_data=0x00. State is IDLE, the lines are released, and the filter is preset to all-ones (filtered clock high).
- Reset mid-frame aborts immediately: the lines are released, no done/error pulse is produced, and the counters are cleared.
- Input path:
  - Both pad inputs pass through a 2-flop synchroniser.
  - Filtered clock goes to 0 when all FILTER_LEN recent samples are 0, goes to 1 when all are 1, and otherwise holds.
  - fall = filtered clock changes 1→0; the event lasts one cycle.
  - Data is sampled from the synchronised data line in the cycle of fall.
- Open-drain rule: the *_oe outputs are registered. The pads drive 0 when oe=1 and never drive 1.
- tx_ready = (state==IDLE) && filtered clock high && !fall.
- States and transitions:
  - IDLE:
    - fall → RX; the bit count is cleared and this fall samples the start bit.
    - Otherwise, tx_valid && tx_ready → TX_INHIBIT, latching tx_data and computing odd parity (parity = ~^tx_data).
    - Priority: a fall in the same cycle as tx_valid goes to RX, and the request stays pending.
  - RX:
    - Each fall shifts the data bit in, LSB first (11 bits: start, d0..d7, parity, stop) and reloads the timer.
    - After the 11th bit the frame is checked: start==0, stop==1, and ^{d7..d0,parity}==1 (odd parity).
    - Pass: rx_data<=byte and rx_valid pulses. Fail: rx_error pulses and rx_data is unchanged.
    - Either way → RX_WAIT.
    - Timer expiry before the 11th bit: rx_error pulses → IDLE.
  - RX_WAIT: filtered clock high → IDLE. The RX_WAIT-to-IDLE path never pulses rx_error.
  - TX_INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles. In the last cycle ps2_data_oe goes to 1 (start bit) → TX_REQ.
  - TX_REQ: ps2_clk_oe=0 and the data line is held low. The timer is reloaded; TX_DATA is entered with the bit index at 0.
  - TX_DATA:
    - On each fall the next bit goes out on ps2_data_oe (oe = ~bit): falls 1–8 carry d0..d7, fall 9 carries parity, fall 10 releases data (stop).
    - Data changes only at fall cycles.
    - After fall 10 → TX_ACK.
  - TX_ACK: at the next fall, sample the data line; ACK = data low. → TX_END.
  - TX_END:
    - Wait until the filtered clock is high and the synchronised data line is high.
    - Then tx_done pulses with tx_error = !ACK → IDLE.
- Transmit timeout: in TX_DATA, TX_ACK or TX_END, timer expiry → both lines released, tx_done=1, tx_error=1 → IDLE.
- Timer behaviour:
  - Counts down and reloads on every fall.
  - Expiry = reaching 0.
  - No wrap-around; it saturates at 0.
- Frames received while transmitting are never reported on the rx outputs.
- Only one transaction is in flight at a time. tx_valid is ignored while busy.

Test Plan:
- Device sends 0x1C (start 0, bits LSB first, parity 0, stop 1) with a 60 µs clock period → exactly one rx_valid pulse, rx_data=0x1C, no rx_error, busy returns to 0.
- Device sends 0x1C with parity 1 → one rx_error pulse, rx_data keeps its previous value, no rx_valid. Repeat with stop=0 → same result.
- Device stops clocking after 5 bits → rx_error pulses TIMEOUT_CYCLES (±2) cycles after the last fall, state is IDLE, and a following valid frame of 0xAA is received correctly.
- tx_data=0xFF, tx_valid=1; a device model clocks and ACKs:
  - ps2_clk_oe=1 for 1600 cycles, then start 0.
  - Bits 1×8, parity 1, stop released.
  - tx_done=1 with tx_error=0.
- Same transmit with no ACK (device leaves data high at the 11th fall) → tx_done=1, tx_error=1. Device never clocks → tx_error=1 after the timeout, both oe=0.
- Clock glitches shorter than FILTER_LEN cycles during RX produce no extra bits (0x55 is still received). Reset asserted mid-TX_DATA → next cycle both oe=0, busy=0, no tx_done pulse.

Source files
------------

// File: rtl/ps2_host.sv
// PS/2 host controller: synchronises and glitch-filters the pad inputs,
// receives 11-bit device frames with framing/parity checks, and sends
// command bytes using the inhibit / request-to-send sequence. Both lines
// are open-drain: an *_oe of 1 pulls the line low, 0 releases it.
//
// Transmit handshake: tx_valid/tx_ready. A byte is accepted on the rising
// clk edge where both are high. tx_ready never looks at tx_valid. The
// requester must hold tx_data stable while tx_valid is high. Once a
// transaction is in flight, tx_valid is ignored until busy drops.
module ps2_host #(
  parameter int FILTER_LEN     = 8,
  parameter int INHIBIT_CYCLES = 1600,
  parameter int TIMEOUT_CYCLES = 32000,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX         = 3'd1,
    S_RX_WAIT    = 3'd2,
    S_TX_INHIBIT = 3'd3,
    S_TX_REQ     = 3'd4,
    S_TX_DATA    = 3'd5,
    S_TX_ACK     = 3'd6,
    S_TX_END     = 3'd7
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] INHIBIT_LOAD = TIMER_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);

  // Input path
  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  fclk_q;
  logic                  fclk_d;
  logic                  data_s;
  logic                  fall;

  // Control and datapath
  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             rx_sh_q, rx_sh_d;
  logic [10:0]            rx_frame;
  logic                   rx_frame_ok;
  logic [9:0]             tx_frame_q, tx_frame_d;
  logic                   ack_q, ack_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_error_q, rx_error_d;
  logic                   tx_done_q, tx_done_d;
  logic                   tx_error_q, tx_error_d;
  logic                   timer_zero;
  logic                   accept;

  // Two-flop synchronisers and clock filter history; idle lines read high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= '1;
      fclk_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
      fclk_q      <= fclk_d;
    end
  end

  // Filtered clock only moves when the whole sample window agrees
  always_comb begin
    fclk_d = fclk_q;
    if (filt_q == '0) begin
      fclk_d = 1'b0;
    end else if (filt_q == '1) begin
      fclk_d = 1'b1;
    end
  end

  assign data_s     = data_sync_q[1];
  assign fall       = fclk_q & ~fclk_d;
  assign timer_zero = (timer_q == '0);
  // Gating with reset keeps every output low while reset is held
  assign tx_ready   = ~reset && (state_q == S_IDLE) && fclk_q && ~fall;
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state_q != S_IDLE);

  // Frame as it stands including the bit sampled at this fall:
  // [0] start, [8:1] data LSB first, [9] parity, [10] stop
  assign rx_frame    = {data_s, rx_sh_q};
  assign rx_frame_ok = ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a device fall always wins over a pending transmit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fall)        state_d = S_RX;
        else if (accept) state_d = S_TX_INHIBIT;
      end
      S_RX: begin
        if (fall && bit_cnt_q == 4'd10) state_d = S_RX_WAIT;
        else if (!fall && timer_zero)   state_d = S_IDLE;
      end
      S_RX_WAIT: begin
        if (fclk_q) state_d = S_IDLE;
      end
      S_TX_INHIBIT: begin
        if (timer_zero) state_d = S_TX_REQ;
      end
      S_TX_REQ: begin
        state_d = S_TX_DATA;
      end
      S_TX_DATA: begin
        if (fall && bit_cnt_q == 4'd9) state_d = S_TX_ACK;
        else if (!fall && timer_zero)  state_d = S_IDLE;
      end
      S_TX_ACK: begin
        if (fall)            state_d = S_TX_END;
        else if (timer_zero) state_d = S_IDLE;
      end
      S_TX_END: begin
        if (fclk_q && data_s) state_d = S_IDLE;
        else if (timer_zero)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; line enables and pulses are registered
  always_comb begin
    timer_d    = timer_zero ? timer_q : timer_q - TIMER_ONE;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    tx_frame_d = tx_frame_q;
    ack_d      = ack_q;
    clk_oe_d   = 1'b0;
    data_oe_d  = data_oe_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (fall) begin
          timer_d   = TIMEOUT_LOAD;
          bit_cnt_d = 4'd1;
          rx_sh_d   = rx_frame[10:1];
        end else if (accept) begin
          tx_frame_d = {1'b1, ~^tx_data, tx_data};
          timer_d    = INHIBIT_LOAD;
          clk_oe_d   = 1'b1;
          data_oe_d  = (INHIBIT_CYCLES == 1);
        end
      end
      S_RX: begin
        if (fall) begin
          timer_d   = TIMEOUT_LOAD;
          bit_cnt_d = bit_cnt_q + 4'd1;
          rx_sh_d   = rx_frame[10:1];
          if (bit_cnt_q == 4'd10) begin
            if (rx_frame_ok) begin
              rx_data_d  = rx_frame[8:1];
              rx_valid_d = 1'b1;
            end else begin
              rx_error_d = 1'b1;
            end
          end
        end else if (timer_zero) begin
          rx_error_d = 1'b1;
        end
      end
      S_TX_INHIBIT: begin
        // Clock held low for the whole state; data joins it in the last cycle
        clk_oe_d  = ~timer_zero;
        data_oe_d = (timer_q <= TIMER_ONE);
      end
      S_TX_REQ: begin
        timer_d   = TIMEOUT_LOAD;
        bit_cnt_d = 4'd0;
        data_oe_d = 1'b1;
      end
      S_TX_DATA: begin
        if (fall) begin
          timer_d   = TIMEOUT_LOAD;
          data_oe_d = ~tx_frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (timer_zero) begin
          data_oe_d  = 1'b0;
          tx_done_d  = 1'b1;
          tx_error_d = 1'b1;
        end
      end
      S_TX_ACK: begin
        if (fall) begin
          timer_d = TIMEOUT_LOAD;
          ack_d   = ~data_s;
        end else if (timer_zero) begin
          data_oe_d  = 1'b0;
          tx_done_d  = 1'b1;
          tx_error_d = 1'b1;
        end
      end
      S_TX_END: begin
        if (fclk_q && data_s) begin
          tx_done_d  = 1'b1;
          tx_error_d = ~ack_q;
        end else if (timer_zero) begin
          data_oe_d  = 1'b0;
          tx_done_d  = 1'b1;
          tx_error_d = 1'b1;
        end
      end
      default: begin
        data_oe_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      bit_cnt_q  <= 4'd0;
      rx_sh_q    <= 10'd0;
      rx_data_q  <= 8'h00;
      tx_frame_q <= 10'd0;
      ack_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      tx_frame_q <= tx_frame_d;
      ack_q      <= ack_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_error    = rx_error_q;
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;

endmodule
